// File: rtl/gate_truth_tester_pkg.sv
// Shared types and constants for the two-input gate block tester.
// Bit order of the gate output bus: AND, OR, NAND, NOR, XOR, XNOR, NOT a.
package gate_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int NUM_GATES = 7;

   localparam int G_AND  = 0;
   localparam int G_OR   = 1;
   localparam int G_NAND = 2;
   localparam int G_NOR  = 3;
   localparam int G_XOR  = 4;
   localparam int G_XNOR = 5;
   localparam int G_NOT  = 6;

   // Reference truth vector of a healthy gate block for inputs a, b.
   function automatic logic [NUM_GATES-1:0] expected_z(input logic a, input logic b);
      logic [NUM_GATES-1:0] z;
      z         = '0;
      z[G_AND]  = a & b;
      z[G_OR]   = a | b;
      z[G_NAND] = ~(a & b);
      z[G_NOR]  = ~(a | b);
      z[G_XOR]  = a ^ b;
      z[G_XNOR] = ~(a ^ b);
      z[G_NOT]  = ~a;
      return z;
   endfunction

endpackage

// File: rtl/gate_truth_tester_if.sv
// Bundle between the tester and its environment: run control, gate
// stimulus/response and the result/fault-localisation outputs.
interface gate_truth_tester_if;
   import gate_test_pkg::*;

   logic                 start;
   logic                 a_o;
   logic                 b_o;
   logic [NUM_GATES-1:0] z_i;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [NUM_GATES-1:0] err_mask;
   logic                 err_valid;
   logic [1:0]           err_vec;

   // Tester side.
   modport master (
      input  start,
      input  z_i,
      output a_o,
      output b_o,
      output busy,
      output done,
      output pass,
      output err_mask,
      output err_valid,
      output err_vec
   );

   // Environment side: requests runs, supplies gate outputs, reads results.
   modport slave (
      output start,
      output z_i,
      input  a_o,
      input  b_o,
      input  busy,
      input  done,
      input  pass,
      input  err_mask,
      input  err_valid,
      input  err_vec
   );

endinterface

// File: rtl/gate_truth_tester.sv
// Stimulus/response sequencer for the two-input gate block: walks {a,b}
// through 00,01,10,11, waits SETTLE_CYCLES after each drive, samples z
// once per vector and accumulates mismatches with first-failure capture.
module gate_truth_tester
   import gate_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   gate_truth_tester_if.master bus
);

   // Reload value for the settle down-counter; only used when SETTLE_CYCLES > 0.
   localparam logic [3:0] SETTLE_RELOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

   state_t               r_state;
   state_t               w_state_next;
   logic [1:0]           r_vec;
   logic [3:0]           r_cnt;
   logic [NUM_GATES-1:0] r_err_mask;
   logic                 r_err_valid;
   logic [1:0]           r_err_vec;
   logic                 r_pass;

   logic [NUM_GATES-1:0] w_mismatch;
   logic [NUM_GATES-1:0] w_mask_next;

   assign w_mismatch  = bus.z_i ^ expected_z(r_vec[1], r_vec[0]);
   assign w_mask_next = r_err_mask | w_mismatch;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (bus.start) w_state_next = ST_DRIVE;
         ST_DRIVE:  w_state_next = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
         ST_SETTLE: if (r_cnt == 4'd0) w_state_next = ST_CHECK;
         ST_CHECK:  w_state_next = (r_vec == 2'd3) ? ST_DONE : ST_DRIVE;
         ST_DONE:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Vector/settle counters and result accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec       <= 2'd0;
         r_cnt       <= 4'd0;
         r_err_mask  <= '0;
         r_err_valid <= 1'b0;
         r_err_vec   <= 2'd0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_vec       <= 2'd0;
                  r_cnt       <= 4'd0;
                  r_err_mask  <= '0;
                  r_err_valid <= 1'b0;
                  r_err_vec   <= 2'd0;
                  r_pass      <= 1'b0;
               end
            end
            ST_DRIVE: begin
               r_cnt <= SETTLE_RELOAD;
            end
            ST_SETTLE: begin
               if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            end
            ST_CHECK: begin
               r_err_mask <= w_mask_next;
               if ((w_mismatch != '0) && !r_err_valid) begin
                  r_err_valid <= 1'b1;
                  r_err_vec   <= r_vec;
               end
               // Verdict is registered here so it is already visible in the DONE cycle.
               if (r_vec == 2'd3) begin
                  r_pass <= (w_mask_next == '0);
               end else begin
                  r_vec <= r_vec + 2'd1;
               end
            end
            ST_DONE: begin
               r_vec <= 2'd0;
            end
            default: ;
         endcase
      end
   end

   // Output decode: stimulus only while a vector is active, idle low otherwise.
   always_comb begin
      bus.a_o       = 1'b0;
      bus.b_o       = 1'b0;
      if ((r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_CHECK)) begin
         bus.a_o = r_vec[1];
         bus.b_o = r_vec[0];
      end
      bus.busy      = (r_state != ST_IDLE);
      bus.done      = (r_state == ST_DONE);
      bus.pass      = r_pass;
      bus.err_mask  = r_err_mask;
      bus.err_valid = r_err_valid;
      bus.err_vec   = r_err_vec;
   end

endmodule

// File: tb/tb_gate_truth_tester.sv
// Bench for gate_truth_tester: a settle-2 instance exercised against a
// table of injected stuck-at faults, plus reset-mid-run and a settle-0
// instance with start held high.
module tb_gate_truth_tester;

   logic clk;
   logic rst;

   int n_checks;
   int n_errors;

   // Stuck-at masks applied to the settle-2 instance's gate outputs.
   logic [6:0] stuck0;
   logic [6:0] stuck1;

   gate_truth_tester_if if2 ();
   gate_truth_tester_if if0 ();

   gate_truth_tester #(.SETTLE_CYCLES(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.master)
   );

   gate_truth_tester #(.SETTLE_CYCLES(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Healthy gate block as a lookup of hand-written rows, bit 6..0 = NOTa,XNOR,XOR,NOR,NAND,OR,AND.
   function automatic logic [6:0] gate_block(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 7'b1101100;
         2'b01:   return 7'b1010110;
         2'b10:   return 7'b0010110;
         default: return 7'b0100011;
      endcase
   endfunction

   assign if2.z_i = (gate_block(if2.a_o, if2.b_o) & ~stuck0) | stuck1;
   assign if0.z_i = gate_block(if0.a_o, if0.b_o);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [6:0] s0;
      logic [6:0] s1;
      logic [6:0] mask;
      logic       valid;
      logic [1:0] vec;
      logic       pass;
   } vec_t;

   vec_t tbl[11];

   // One full run on the settle-2 instance with the current stuck masks.
   task automatic run2(input vec_t t);
      int  n;
      bit  stim_ok;
      logic [1:0] ab;
      stim_ok = 1'b1;
      @(negedge clk) if2.start = 1'b1;
      @(negedge clk) if2.start = 1'b0;
      // First DRIVE cycle: results of the previous run must already be cleared.
      chk({t.name, " busy_at_drive"}, 32'(if2.busy), 32'd1);
      chk({t.name, " cleared_at_start"}, {22'd0, if2.err_valid, if2.err_mask, if2.err_vec}, 32'd0);
      n = 1;
      while (!if2.done && n < 40) begin
         ab = {if2.a_o, if2.b_o};
         if (ab !== 2'((n - 1) / 4) || if2.busy !== 1'b1) stim_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk({t.name, " done_cycle"}, 32'(n), 32'd17);
      chk({t.name, " stimulus"}, 32'(stim_ok), 32'd1);
      chk({t.name, " done_ab_busy"}, {29'd0, if2.a_o, if2.b_o, if2.busy}, 32'b001);
      chk({t.name, " err_mask"}, 32'(if2.err_mask), 32'(t.mask));
      chk({t.name, " err_valid"}, 32'(if2.err_valid), 32'(t.valid));
      if (t.valid) chk({t.name, " err_vec"}, 32'(if2.err_vec), 32'(t.vec));
      chk({t.name, " pass"}, 32'(if2.pass), 32'(t.pass));
      @(negedge clk);
      chk({t.name, " idle_after"}, {29'd0, if2.busy, if2.done, if2.pass}, {31'd0, t.pass});
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t t;
      int   n;
      int   dn[$];

      n_checks   = 0;
      n_errors   = 0;
      stuck0     = '0;
      stuck1     = '0;
      if2.start  = 1'b0;
      if0.start  = 1'b0;
      rst        = 1'b1;

      tbl[0]  = '{"clean",        7'h00,        7'h00,        7'b0000000, 1'b0, 2'b00, 1'b1};
      tbl[1]  = '{"xor_sa0",      7'b0010000,   7'h00,        7'b0010000, 1'b1, 2'b01, 1'b0};
      tbl[2]  = '{"not_sa1",      7'h00,        7'b1000000,   7'b1000000, 1'b1, 2'b10, 1'b0};
      tbl[3]  = '{"clean_rerun",  7'h00,        7'h00,        7'b0000000, 1'b0, 2'b00, 1'b1};
      tbl[4]  = '{"and_sa0",      7'b0000001,   7'h00,        7'b0000001, 1'b1, 2'b11, 1'b0};
      tbl[5]  = '{"and_sa1",      7'h00,        7'b0000001,   7'b0000001, 1'b1, 2'b00, 1'b0};
      tbl[6]  = '{"or_sa0",       7'b0000010,   7'h00,        7'b0000010, 1'b1, 2'b01, 1'b0};
      tbl[7]  = '{"nand_sa1",     7'h00,        7'b0000100,   7'b0000100, 1'b1, 2'b11, 1'b0};
      tbl[8]  = '{"nor_sa0",      7'b0001000,   7'h00,        7'b0001000, 1'b1, 2'b00, 1'b0};
      tbl[9]  = '{"xnor_sa1",     7'h00,        7'b0100000,   7'b0100000, 1'b1, 2'b01, 1'b0};
      tbl[10] = '{"and0_not1",    7'b0000001,   7'b1000000,   7'b1000001, 1'b1, 2'b10, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_ctrl", {29'd0, if2.busy, if2.done, if2.pass}, 32'd0);
      chk("reset_err", {22'd0, if2.err_valid, if2.err_mask, if2.err_vec}, 32'd0);
      chk("reset_ab", {30'd0, if2.a_o, if2.b_o}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_start", {30'd0, if2.busy, if2.done}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         stuck0 = tbl[i].s0;
         stuck1 = tbl[i].s1;
         run2(tbl[i]);
      end

      // Reset during vector 2's settle window after a fault was already recorded.
      stuck0 = 7'b0010000;
      stuck1 = '0;
      @(negedge clk) if2.start = 1'b1;
      @(negedge clk) if2.start = 1'b0;
      n = 1;
      while (n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("midrun_vec2", {29'd0, if2.a_o, if2.b_o, if2.err_valid}, 32'b101);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ctrl", {29'd0, if2.busy, if2.done, if2.pass}, 32'd0);
      chk("rst_mid_err", {22'd0, if2.err_valid, if2.err_mask, if2.err_vec}, 32'd0);
      chk("rst_mid_ab", {30'd0, if2.a_o, if2.b_o}, 32'd0);
      rst = 1'b0;
      stuck0 = '0;
      t = '{"after_rst", 7'h00, 7'h00, 7'b0000000, 1'b0, 2'b00, 1'b1};
      run2(t);

      // Settle-0 instance with start held high: done every 10 cycles.
      @(negedge clk) if0.start = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (if0.done) dn.push_back(k + 1);
      end
      if0.start = 1'b0;
      chk("s0_done_count", 32'(dn.size()), 32'd3);
      if (dn.size() == 3) begin
         chk("s0_done_first", 32'(dn[0]), 32'd9);
         chk("s0_done_second", 32'(dn[1]), 32'd19);
         chk("s0_done_third", 32'(dn[2]), 32'd29);
      end
      n = 0;
      while (!if0.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("s0_last_done_seen", 32'(if0.done), 32'd1);
      chk("s0_pass", 32'(if0.pass), 32'd1);
      @(negedge clk);
      chk("s0_idle", {30'd0, if0.busy, if0.done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gate_truth_tester.md
# gate_truth_tester

Self-checking stimulus/response sequencer for the two-input basic-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and samples the 7-bit gate output bus `z` after a programmable settle time. It compares each sample against the expected truth table and reports pass/fail with fault localisation. It sits directly around the gate block: upstream as its stimulus source, downstream as the consumer of `z`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling `z`. Legal range 0..15.

Ports:
- `clk`  in  1  — the single clock; all state on rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `start`  in  1  — request a test run; sampled only in IDLE.
- `a_o`  out  1  — stimulus to gate block input `a`.
- `b_o`  out  1  — stimulus to gate block input `b`.
- `z_i`  in  7  — gate block outputs. Bit order: [0] AND, [1] OR, [2] NAND, [3] NOR, [4] XOR, [5] XNOR, [6] NOT a.
- `busy`  out  1  — high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  — one-cycle pulse at end of run.
- `pass`  out  1  — held result of last completed run; 1 = no mismatch.
- `err_mask`  out  7  — OR of per-bit mismatches across the run.
- `err_valid`  out  1  — at least one mismatch seen in current/last run.
- `err_vec`  out  2  — `{a,b}` of the first failing vector; valid when `err_valid`.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- 2-bit vector counter `vec`; `{a_o,b_o} = vec` while in DRIVE/SETTLE/CHECK. Order: 00, 01, 10, 11.
- IDLE: `a_o=b_o=0`. `start=1` → DRIVE with `vec=0`. On acceptance, clear `err_mask`, `err_valid`, `err_vec`, `pass`.
- DRIVE: 1 cycle. Then SETTLE if `SETTLE_CYCLES>0`, else CHECK.
- SETTLE: exactly `SETTLE_CYCLES` cycles, down-counter, then CHECK.
- CHECK: 1 cycle. Compare `z_i` with `expected_z(vec)` = {~a, ~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b}.
  - `err_mask |= mismatch`.
  - If mismatch is nonzero and `err_valid=0`: set `err_valid`, latch `err_vec=vec`.
  - If `vec==3` → DONE; else `vec++` → DRIVE.
- DONE: 1 cycle. `done=1`, `pass = (err_mask==0)` (including the final CHECK's contribution), `a_o=b_o=0`. Then → IDLE.
- `start` in any non-IDLE state, including DONE, is ignored (not queued). `start` held high starts a new run on each return to IDLE.
- `pass`, `err_*` hold their values from DONE until the next accepted `start` or reset.

## Timing
- Reset values: all outputs 0, state IDLE, `vec=0`, settle counter 0.
- Reset mid-run: next cycle IDLE, all outputs 0, no `done` pulse.
- Per vector: 2+S cycles (S = `SETTLE_CYCLES`). `{a_o,b_o}` is stable for exactly that span.
- `start` sampled at cycle T:
  - DRIVE at T+1.
  - First CHECK at T+2+S.
  - `done` at T+1+4·(2+S). With S=2 this is T+17; with S=0 it is T+9.
- `z_i` is sampled only in CHECK. `z_i` is a combinational function of `a_o`/`b_o`, so S=0 is legal for a direct connection.
- `busy` is high for 4·(2+S)+1 cycles per run.

## Structure
- Package `gate_test_pkg`:
  - state enum;
  - `NUM_GATES=7`;
  - bit-index constants `G_AND`..`G_NOT`;
  - function `expected_z(a,b)` returning the 7-bit truth vector.
- No sub-module. Single FSM with vector counter and settle counter, roughly 150 lines.
- Top-level test harness instantiates `gate_truth_tester` wired to the gate block.

## Test plan
- Correct gate block, S=2, `start` pulse at cycle 0 → `done` at cycle 17; `pass=1`, `err_mask=0`, `err_valid=0`.
- `z_i[4]` forced to 0 → `err_mask=7'b0010000`, `err_vec=2'b01`, `err_valid=1`, `pass=0`.
- Monitor stimulus, S=2 → `{a_o,b_o}` = 00, 01, 10, 11, each held 4 cycles, then 00 in DONE/IDLE.
- `rst` asserted during vector 2's SETTLE → next cycle `busy=0`, outputs 0, no `done`. New `start` → full 17-cycle run, `pass=1`.
- S=0, `start` held high continuously → `done` every 10 cycles (9 active + 1 IDLE). Extra `start` during `busy` is ignored.
- Failing run (`z_i[6]` stuck 1 → `err_mask=7'b1000000`, `err_vec=2'b10`), then fault removed and rerun → `err_*` cleared at start, `pass=1` at second `done`.
